seq_divider: RTL and testbench

Iterative 32-bit signed integer divider for the multdiv unit. It is the inverse operation to the adder-based multiply path and sits beside the multiplier under the same start/ready handshake. It retires one quotient bit per clock using restoring shift-subtract. Trial subtraction is built on the team's lookahead adder, computing A + ~B + 1. Fixed latency of 33 cycles from start to result-ready, regardless of operand values.

---
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative 32-bit signed divider: restoring shift-subtract, one quotient bit per clock.
// Fixed 33-cycle latency from start strobe to the one-cycle result-ready pulse.
module seq_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    // Partial remainder always stays below |B| <= 2^31, so bit 32 is never kept.
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] r_shift, diff;
    logic [31:0] q_next;
    logic [4:0]  bit_idx;
    logic        q_bit;

    always_comb begin
        abs_a   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        abs_b   = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
        bit_idx = 5'd31 - count_q;
        r_shift = {r_q, a_q[bit_idx]};
        diff    = r_shift + ~{1'b0, b_q} + 33'd1;
        q_bit   = ~diff[32];
        q_next  = q_q;
        q_next[bit_idx] = q_bit;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        q_d      = q_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (ctrl_DIV) begin
            // A start in any state (including RUN/DONE) restarts from scratch.
            state_d = StRun;
            count_d = 5'd0;
            a_d     = abs_a;
            b_d     = abs_b;
            r_d     = 32'd0;
            q_d     = 32'd0;
            neg_d   = data_operandA[31] ^ data_operandB[31];
            dz_d    = (data_operandB == 32'd0);
        end else begin
            case (state_q)
                StRun: begin
                    r_d     = q_bit ? diff[31:0] : r_shift[31:0];
                    q_d     = q_next;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d  = StDone;
                        exc_d    = dz_q;
                        result_d = dz_q  ? 32'd0 :
                                   neg_q ? (~q_next + 32'd1) : q_next;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            count_q  <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            r_q      <= 32'd0;
            q_q      <= 32'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            q_q      <= q_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus restart, reset and back-to-back sequences.
module tb_seq_divider;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the negedge right after the capture edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!data_resultRDY && n < 60);
    endtask

    int n;
    int pulses;

    initial begin
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        reset_n       = 1'b0;

        vecs[0] = '{32'd100,      32'd7,          32'd14,         1'b0};
        vecs[1] = '{32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   1'b0};
        vecs[2] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         1'b0};
        vecs[3] = '{32'd7,        32'hFFFFFF9C,   32'd0,          1'b0};
        vecs[4] = '{32'd5,        32'd0,          32'd0,          1'b1};
        vecs[5] = '{32'd9,        32'd3,          32'd3,          1'b0};
        vecs[6] = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1'b0};
        vecs[7] = '{32'h80000000, 32'd1,          32'h80000000,   1'b0};
        vecs[8] = '{32'h7FFFFFFF, 32'd2,          32'h3FFFFFFF,   1'b0};
        vecs[9] = '{32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   1'b0};

        repeat (2) @(negedge clock);
        chk("reset result", data_result, 32'd0);
        chk("reset exc",    {31'd0, data_exception}, 32'd0);
        chk("reset rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy",   {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            start(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
            wait_rdy(n);
            chk($sformatf("v%0d latency", i), n, 32);
            chk($sformatf("v%0d result", i), data_result, vecs[i].q);
            chk($sformatf("v%0d exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
            @(negedge clock);
            chk($sformatf("v%0d rdy drop", i), {31'd0, data_resultRDY}, 32'd0);
            chk($sformatf("v%0d busy drop", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d result hold", i), data_result, vecs[i].q);
        end

        // Restart mid-run: only the second operation may pulse.
        start(32'd1000, 32'd10);
        pulses = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        start(32'd81, 32'd9);
        n = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                n = c;
                chk("restart result", data_result, 32'd9);
            end
        end
        chk("restart pulses", pulses, 1);
        chk("restart latency", n, 32);

        // Async reset mid-operation clears outputs and suppresses the pulse.
        start(32'd50, 32'd5);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset result", data_result, 32'd0);
        chk("mid reset busy",   {31'd0, busy}, 32'd0);
        chk("mid reset rdy",    {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) pulses++;
        end
        chk("post reset quiet", pulses, 0);

        // Back-to-back: each new start lands on the DONE cycle.
        start(32'd20, 32'd4);
        wait_rdy(n);
        chk("b2b0 latency", n, 32);
        chk("b2b0 result", data_result, 32'd5);
        start(32'd21, 32'd7);
        chk("b2b1 busy kept", {31'd0, busy}, 32'd1);
        wait_rdy(n);
        chk("b2b1 spacing", n + 1, 33);
        chk("b2b1 result", data_result, 32'd3);
        start(32'hFFFFFF38, 32'd8);
        wait_rdy(n);
        chk("b2b2 spacing", n + 1, 33);
        chk("b2b2 result", data_result, 32'hFFFFFFE7);
        @(negedge clock);
        chk("b2b end busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
